div_ratio_ctrl: RTL and testbench

//  Run-time controller for the integer clock divider. Accepts divide-ratio

---
 rtl/div_ratio_ctrl.sv | 128 ++++++++++++
 tb/tb_div_ratio_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: run-time controller for the integer clock divider.
// Ratio updates arrive over a valid/ready handshake. While the divider is
// running, an update is held pending and swapped in only at a period
// boundary, so clk_div_out never produces a runt pulse. A stop request
// always lets the current period finish before the divider goes idle.
module div_ratio_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_div_out,
  output logic             tick,
  output logic [CNT_W-1:0] active_div,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic             pend_valid;

  logic             cfg_xfer;
  logic             cfg_legal;
  logic             boundary;
  logic [CNT_W-1:0] next_div;
  logic [CNT_W-1:0] next_half;
  logic [CNT_W-1:0] next_cnt;

  assign cfg_ready = !pend_valid;
  assign busy      = (state != ST_IDLE);
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign cfg_legal = (cfg_div >= CNT_W'(2));

  // Last cycle of the current period; only meaningful while counting.
  assign boundary  = (state != ST_IDLE) && (cnt == active_div - CNT_W'(1));

  // At a boundary the next period already runs with the pending ratio, so the
  // output level for cnt=0 must be derived from that ratio, not the old one.
  assign next_div  = (boundary && pend_valid) ? pend_div : active_div;
  assign next_half = next_div >> 1;
  assign next_cnt  = boundary ? '0 : cnt + CNT_W'(1);

  // Run/stop sequencing, period counter and the registered divided clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      clk_div_out <= 1'b0;
      tick        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          tick <= 1'b0;
          if (en) begin
            state       <= ST_RUN;
            clk_div_out <= 1'b1;
          end else begin
            clk_div_out <= 1'b0;
          end
        end
        ST_RUN: begin
          cnt         <= next_cnt;
          tick        <= boundary;
          clk_div_out <= (next_cnt < next_half);
          if (!en) state <= ST_STOP;
        end
        ST_STOP: begin
          tick <= boundary;
          if (boundary) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            clk_div_out <= 1'b0;
          end else begin
            cnt         <= next_cnt;
            clk_div_out <= (next_cnt < next_half);
          end
        end
        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          clk_div_out <= 1'b0;
          tick        <= 1'b0;
        end
      endcase
    end
  end

  // Ratio bookkeeping: active ratio, pending flag and sticky illegal-ratio flag.
  // A transfer needs pend_valid=0, so it never collides with a pending apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_div <= CNT_W'(DEFAULT_DIV);
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        active_div <= pend_div;
        pend_valid <= 1'b0;
      end
      if (cfg_xfer) begin
        if (!cfg_legal) begin
          cfg_err <= 1'b1;
        end else begin
          cfg_err <= 1'b0;
          if (state == ST_IDLE) active_div <= cfg_div;
          else                  pend_valid <= 1'b1;
        end
      end
    end
  end

  // Pending ratio storage; only meaningful while pend_valid is set.
  always_ff @(posedge clk) begin
    if (cfg_xfer && cfg_legal && (state != ST_IDLE)) pend_div <= cfg_div;
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed testbench for div_ratio_ctrl with hand-computed expectations.
module tb_div_ratio_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       clk_div_out;
  logic       tick;
  logic [7:0] active_div;
  logic       busy;
  logic       cfg_err;

  int total;
  int bad;

  div_ratio_ctrl #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .clk_div_out(clk_div_out), .tick(tick),
    .active_div(active_div), .busy(busy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    step();
    rst = 1'b0;
  endtask

  // en=1 and one edge: afterwards the first cycle of a period is visible.
  task automatic start_run();
    en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (clk_div_out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", clk_div_out); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    total++; if (active_div !== 8'd4) begin bad++; $display("FAIL reset_div got=%0d exp=4", active_div); end
  endtask

  task automatic test_default_run();
    logic [0:7] e_out;
    logic [0:7] e_tick;
    e_out  = 8'b11001100;
    e_tick = 8'b00001000;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (clk_div_out !== e_out[i]) begin bad++; $display("FAIL run4_out[%0d] got=%b exp=%b", i, clk_div_out, e_out[i]); end
      total++; if (tick !== e_tick[i]) begin bad++; $display("FAIL run4_tick[%0d] got=%b exp=%b", i, tick, e_tick[i]); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL run4_busy[%0d] got=%b exp=1", i, busy); end
    end
  endtask

  task automatic test_update_in_run();
    logic [0:8] e_out;
    logic [0:8] e_tick;
    logic [0:8] e_rdy;
    logic [7:0] e_div;
    e_out  = 9'b001110001;
    e_tick = 9'b001000001;
    e_rdy  = 9'b001111111;
    do_reset();
    start_run();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL upd_ready_pre got=%b exp=1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e_div = (i < 2) ? 8'd4 : 8'd6;
      total++; if (clk_div_out !== e_out[i]) begin bad++; $display("FAIL upd_out[%0d] got=%b exp=%b", i, clk_div_out, e_out[i]); end
      total++; if (tick !== e_tick[i]) begin bad++; $display("FAIL upd_tick[%0d] got=%b exp=%b", i, tick, e_tick[i]); end
      total++; if (cfg_ready !== e_rdy[i]) begin bad++; $display("FAIL upd_ready[%0d] got=%b exp=%b", i, cfg_ready, e_rdy[i]); end
      total++; if (active_div !== e_div) begin bad++; $display("FAIL upd_div[%0d] got=%0d exp=%0d", i, active_div, e_div); end
      step();
    end
  endtask

  task automatic test_idle_load();
    logic [0:9] e_out;
    logic [0:9] e_tick;
    e_out  = 10'b1100011000;
    e_tick = 10'b0000010000;
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    total++; if (active_div !== 8'd5) begin bad++; $display("FAIL idle_div got=%0d exp=5", active_div); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", cfg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (clk_div_out !== e_out[i]) begin bad++; $display("FAIL run5_out[%0d] got=%b exp=%b", i, clk_div_out, e_out[i]); end
      total++; if (tick !== e_tick[i]) begin bad++; $display("FAIL run5_tick[%0d] got=%b exp=%b", i, tick, e_tick[i]); end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    start_run();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", cfg_err); end
    total++; if (active_div !== 8'd4) begin bad++; $display("FAIL ill_div got=%0d exp=4", active_div); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b exp=1", cfg_ready); end
    cfg_valid = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL legal_err got=%b exp=0", cfg_err); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL legal_ready got=%b exp=0", cfg_ready); end
  endtask

  task automatic test_stop();
    logic [0:3] e_tick;
    logic [0:3] e_busy;
    e_tick = 4'b0010;
    e_busy = 4'b1100;
    do_reset();
    start_run();
    step();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (clk_div_out !== 1'b0) begin bad++; $display("FAIL stop_out[%0d] got=%b exp=0", i, clk_div_out); end
      total++; if (tick !== e_tick[i]) begin bad++; $display("FAIL stop_tick[%0d] got=%b exp=%b", i, tick, e_tick[i]); end
      total++; if (busy !== e_busy[i]) begin bad++; $display("FAIL stop_busy[%0d] got=%b exp=%b", i, busy, e_busy[i]); end
    end
  endtask

  task automatic test_boundary_xfer();
    logic [0:7] e_out;
    logic [0:7] e_tick;
    logic [7:0] e_div;
    e_out  = 8'b11001010;
    e_tick = 8'b10001010;
    do_reset();
    start_run();
    step(); step(); step();
    cfg_valid = 1'b1; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e_div = (i < 4) ? 8'd4 : 8'd2;
      total++; if (clk_div_out !== e_out[i]) begin bad++; $display("FAIL bnd_out[%0d] got=%b exp=%b", i, clk_div_out, e_out[i]); end
      total++; if (tick !== e_tick[i]) begin bad++; $display("FAIL bnd_tick[%0d] got=%b exp=%b", i, tick, e_tick[i]); end
      total++; if (active_div !== e_div) begin bad++; $display("FAIL bnd_div[%0d] got=%0d exp=%0d", i, active_div, e_div); end
      step();
    end
  endtask

  task automatic test_reset_midrun();
    logic [0:7] e_out;
    e_out = 8'b11001100;
    do_reset();
    start_run();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd7;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_pend_ready got=%b exp=0", cfg_ready); end
    #2;
    rst = 1'b1; en = 1'b0;
    #1;
    total++; if (active_div !== 8'd4) begin bad++; $display("FAIL mid_div got=%0d exp=4", active_div); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", cfg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (clk_div_out !== 1'b0) begin bad++; $display("FAIL mid_out got=%b exp=0", clk_div_out); end
    step();
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (clk_div_out !== e_out[i]) begin bad++; $display("FAIL mid_run_out[%0d] got=%b exp=%b", i, clk_div_out, e_out[i]); end
      total++; if (active_div !== 8'd4) begin bad++; $display("FAIL mid_run_div[%0d] got=%0d exp=4", i, active_div); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    test_reset();
    test_default_run();
    test_update_in_run();
    test_idle_load();
    test_illegal();
    test_stop();
    test_boundary_xfer();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
